// File: rtl/toy_backup_rename_recover_walker.sv
// rtl/toy_backup_rename_recover_walker.sv - flush-time walker restoring the committed rename map
// Optional feature macro: TOY_RECOVER_SKIP_X0_EN (arch reg 0 hardwired, never restored)
module toy_backup_rename_recover_walker #(
  parameter  int ARCH_REG_NUM     = 32,
  parameter  int RESTORE_WIDTH    = 4,
  parameter  int PHY_REG_ID_WIDTH = 7,
  localparam int ARCH_ID_W        = $clog2(ARCH_REG_NUM),
  localparam int GRP_NUM          = ARCH_REG_NUM / RESTORE_WIDTH,
  localparam int GRP_W            = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_valid_i,
  input  logic [ARCH_REG_NUM*PHY_REG_ID_WIDTH-1:0]   backup_phy_id_i,
  input  logic                                       rt_wr_ready_i,
  output logic [RESTORE_WIDTH-1:0]                   rt_wr_en_o,
  output logic [RESTORE_WIDTH*ARCH_ID_W-1:0]         rt_wr_arch_id_o,
  output logic [RESTORE_WIDTH*PHY_REG_ID_WIDTH-1:0]  rt_wr_phy_id_o,
  output logic                                       recover_busy_o,
  output logic                                       recover_done_o,
  output logic                                       rename_stall_o
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GRP_NUM - 1);

  state_e           state_q;
  logic [GRP_W-1:0] grp_q;
  logic             busy_q;
  logic             done_q;
  logic             beat_fire;
  int               idx;

  // Beat contents: slot s of group g carries arch reg g*RESTORE_WIDTH+s, read live from the backup map
  always_comb begin
    rt_wr_en_o      = '0;
    rt_wr_arch_id_o = '0;
    rt_wr_phy_id_o  = '0;
    idx             = 0;
    if (busy_q) begin
      for (int s = 0; s < RESTORE_WIDTH; s++) begin
        idx = int'(grp_q) * RESTORE_WIDTH + s;
        rt_wr_en_o[s] = 1'b1;
        rt_wr_arch_id_o[s*ARCH_ID_W +: ARCH_ID_W] = ARCH_ID_W'(idx);
        rt_wr_phy_id_o[s*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] =
          backup_phy_id_i[idx*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
`ifdef TOY_RECOVER_SKIP_X0_EN
        if (idx == 0) begin
          rt_wr_en_o[s] = 1'b0;
          rt_wr_arch_id_o[s*ARCH_ID_W +: ARCH_ID_W] = '0;
          rt_wr_phy_id_o[s*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] = '0;
        end
`endif
      end
    end
  end

  assign beat_fire      = busy_q && (|rt_wr_en_o) && rt_wr_ready_i;
  assign recover_busy_o = busy_q;
  assign recover_done_o = done_q;
  assign rename_stall_o = flush_valid_i | busy_q;

  // Walk FSM; a flush always restarts at group 0 and suppresses done for the aborted walk
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_valid_i) begin
            state_q <= WALK;
            busy_q  <= 1'b1;
            grp_q   <= '0;
          end
        end
        WALK: begin
          if (flush_valid_i) begin
            grp_q <= '0;
          end else if (beat_fire) begin
            if (grp_q == LAST_GRP) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              grp_q   <= '0;
            end else begin
              grp_q <= grp_q + GRP_W'(1);
            end
          end
        end
        DONE: begin
          grp_q <= '0;
          if (flush_valid_i) begin
            state_q <= WALK;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          grp_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_backup_rename_recover_walker.sv
// tb/tb_toy_backup_rename_recover_walker.sv - scoreboard bench for the rename recover walker
module tb_toy_backup_rename_recover_walker;
  localparam int AN = 32;
  localparam int RW = 4;
  localparam int PW = 7;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ready;
  logic [AN*PW-1:0]  backup;
  logic [RW-1:0]     en;
  logic [RW*AW-1:0]  arch;
  logic [RW*PW-1:0]  phy;
  logic              busy;
  logic              done;
  logic              stall;

  toy_backup_rename_recover_walker #(
    .ARCH_REG_NUM(AN), .RESTORE_WIDTH(RW), .PHY_REG_ID_WIDTH(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_valid_i(flush), .backup_phy_id_i(backup),
    .rt_wr_ready_i(ready), .rt_wr_en_o(en), .rt_wr_arch_id_o(arch),
    .rt_wr_phy_id_o(phy), .recover_busy_o(busy), .recover_done_o(done),
    .rename_stall_o(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [RW-1:0]    en;
    logic [RW*AW-1:0] arch;
    logic [RW*PW-1:0] phy;
  } beat_t;

  beat_t beat_q[$];
  int    done_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Hand model of a beat: backup slice i holds i+32
  function automatic beat_t mk_beat(input int g);
    beat_t b;
    int idx;
    b = '0;
    for (int s = 0; s < RW; s++) begin
      idx = g * RW + s;
      b.en[s] = 1'b1;
      b.arch[s*AW +: AW] = AW'(idx);
      b.phy[s*PW +: PW]  = PW'(idx + 32);
`ifdef TOY_RECOVER_SKIP_X0_EN
      if (idx == 0) begin
        b.en[s] = 1'b0;
        b.arch[s*AW +: AW] = '0;
        b.phy[s*PW +: PW]  = '0;
      end
`endif
    end
    return b;
  endfunction

  task automatic push_walk(input int from, input int to);
    for (int g = from; g <= to; g++) beat_q.push_back(mk_beat(g));
  endtask

  // Monitor: every offered beat is compared with the queue head; popped only on handshake
  always @(negedge clk) begin
    if (|en) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 64'(en), 64'(0));
      else begin
        chk("beat_en", 64'(en), 64'(beat_q[0].en));
        chk("beat_arch", 64'(arch), 64'(beat_q[0].arch));
        chk("beat_phy", 64'(phy), 64'(beat_q[0].phy));
        if (ready) void'(beat_q.pop_front());
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
      else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
  end

  // Drives cycles T..T+n (flush forced at T); masks are indexed by offset k from T
  task automatic run(input int n, input logic [31:0] busy_m, input logic [31:0] rdy_low_m,
                     input logic [31:0] flush_m, input logic [31:0] rst_m);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      flush = (k == 0) || flush_m[k];
      ready = !rdy_low_m[k];
      rst   = rst_m[k];
      @(negedge clk);
      chk("busy", 64'(busy), 64'(busy_m[k]));
      chk("stall", 64'(stall), 64'(busy_m[k] | flush));
    end
    flush = 1'b0;
    ready = 1'b1;
    rst   = 1'b0;
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < AN; i++) backup[i*PW +: PW] = PW'(i + 32);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_en", 64'(en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_arch", 64'(arch), 64'(0));
    chk("rst_phy", 64'(phy), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));

    // Plain walk, ready high
    @(posedge clk); #1; t0 = cyc;
    push_walk(0, 7); done_q.push_back(t0 + 9);
    run(9, 32'h1FE, 32'h0, 32'h0, 32'h0);

    // Back-pressure for 3 cycles on beat 2
    @(posedge clk); #1; t0 = cyc;
    push_walk(0, 7); done_q.push_back(t0 + 12);
    run(12, 32'hFFE, 32'h38, 32'h0, 32'h0);

    // Re-flush while beat 5 handshakes
    @(posedge clk); #1; t0 = cyc;
    push_walk(0, 5); push_walk(0, 7); done_q.push_back(t0 + 15);
    run(16, 32'h7FFE, 32'h0, 32'h40, 32'h0);

    // Reset during beat 3
    @(posedge clk); #1; t0 = cyc;
    push_walk(0, 3);
    run(6, 32'h1E, 32'h0, 32'h0, 32'h10);
    chk("rst_abort_en", 64'(en), 64'(0));

    // Flush in the DONE cycle
    @(posedge clk); #1; t0 = cyc;
    push_walk(0, 7); done_q.push_back(t0 + 9);
    push_walk(0, 7); done_q.push_back(t0 + 18);
    run(19, 32'h3FDFE, 32'h0, 32'h200, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("beats_left", 64'(beat_q.size()), 64'(0));
    chk("dones_left", 64'(done_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
